hz_text_layer: RTL and testbench

Parametrised text overlay layer for the VGA compositor. It draws a row of N_CHARS 16x16 Hanzi glyphs from an external glyph ROM at a runtime-programmable origin. It adds per-slot glyph codes, a programmable foreground colour, blink, marquee scroll and tear-free frame-synchronous config commit. Its outputs go to the layer mixer as one more RqFlag/RGB source.

---
 rtl/hz_layer_pkg.sv | 27 ++
 rtl/hz_layer_timing.sv | 125 ++++++++++++
 rtl/hz_text_layer.sv | 122 ++++++++++++
 tb/tb_hz_text_layer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hz_layer_pkg.sv
// Shared constants and types for the Hanzi text overlay layer:
// register map, blink/marquee mode encodings and glyph geometry.
package hz_layer_pkg;

  localparam int GLYPH_W         = 16;
  localparam int GLYPH_H         = 16;
  localparam int BYTES_PER_GLYPH = 32;

  localparam logic [4:0] ADDR_CTRL      = 5'd0;
  localparam logic [4:0] ADDR_ORG_X     = 5'd1;
  localparam logic [4:0] ADDR_ORG_Y     = 5'd2;
  localparam logic [4:0] ADDR_FG        = 5'd3;
  localparam logic [4:0] ADDR_CODE_BASE = 5'd8;

  typedef enum logic [1:0] {
    MODE_STATIC        = 2'b00,
    MODE_BLINK         = 2'b01,
    MODE_MARQUEE       = 2'b10,
    MODE_MARQUEE_BLINK = 2'b11
  } hz_mode_e;

  typedef struct packed {
    logic     enable;
    hz_mode_e mode;
  } hz_ctrl_t;

endpackage

// File: rtl/hz_layer_timing.sv
// Shadow/active configuration with frame-synchronous commit, blink phase
// generation and marquee origin stepping for the text layer.
module hz_layer_timing
  import hz_layer_pkg::*;
#(
  parameter int N_CHARS      = 3,
  parameter int N_GLYPHS     = 4,
  parameter int H_ACTIVE     = 640,
  parameter int ORG_X_RST    = 512,
  parameter int ORG_Y_RST    = 96,
  parameter int BLINK_FRAMES = 30,
  parameter int SCROLL_STEP  = 1,
  parameter int CODE_W       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic                           cfg_we,
  input  logic [4:0]                     cfg_addr,
  input  logic [23:0]                    cfg_wdata,
  output logic [9:0]                     o_orgX,
  output logic [8:0]                     o_orgY,
  output logic [23:0]                    o_fg,
  output logic [N_CHARS-1:0][CODE_W-1:0] o_code,
  output logic                           o_enable,
  output logic                           o_visible
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  hz_ctrl_t                       r_shCtrl, r_ctrl;
  logic [9:0]                     r_shOrgX, r_orgX;
  logic [8:0]                     r_shOrgY, r_orgY;
  logic [23:0]                    r_shFg, r_fg;
  logic [N_CHARS-1:0][CODE_W-1:0] r_shCode, r_code;
  logic                           r_dirty;
  logic [CNT_W-1:0]               r_blinkCnt;
  logic                           r_blinkPhase;

  logic [4:0] w_codeIdx;
  logic       w_codeSel;
  logic       w_accept;
  logic [9:0] w_orgXStep;

  assign w_codeIdx  = cfg_addr - ADDR_CODE_BASE;
  assign w_codeSel  = (cfg_addr >= ADDR_CODE_BASE) && (int'(w_codeIdx) < N_CHARS);
  assign w_accept   = cfg_we && ((cfg_addr <= ADDR_FG) || w_codeSel);
  assign w_orgXStep = (int'(r_orgX) < SCROLL_STEP)
                      ? 10'(int'(r_orgX) + H_ACTIVE - SCROLL_STEP)
                      : 10'(int'(r_orgX) - SCROLL_STEP);

  // Commit happens before the shadow write so a write coinciding with
  // frame_start waits for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shCtrl <= '0;
      r_ctrl   <= '0;
      r_shOrgX <= 10'(ORG_X_RST);
      r_orgX   <= 10'(ORG_X_RST);
      r_shOrgY <= 9'(ORG_Y_RST);
      r_orgY   <= 9'(ORG_Y_RST);
      r_shFg   <= 24'hFFFFFF;
      r_fg     <= 24'hFFFFFF;
      for (int i = 0; i < N_CHARS; i++) begin
        r_shCode[i] <= CODE_W'(i % N_GLYPHS);
        r_code[i]   <= CODE_W'(i % N_GLYPHS);
      end
      r_dirty <= 1'b0;
    end else begin
      if (frame_start) begin
        if (r_dirty) begin
          r_ctrl  <= r_shCtrl;
          r_orgX  <= r_shOrgX;
          r_orgY  <= r_shOrgY;
          r_fg    <= r_shFg;
          r_code  <= r_shCode;
          r_dirty <= 1'b0;
        end else if (r_ctrl.mode[1]) begin
          r_orgX   <= w_orgXStep;
          r_shOrgX <= w_orgXStep;
        end
      end
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_CTRL:  r_shCtrl <= hz_ctrl_t'(cfg_wdata[2:0]);
          ADDR_ORG_X: r_shOrgX <= cfg_wdata[9:0];
          ADDR_ORG_Y: r_shOrgY <= cfg_wdata[8:0];
          ADDR_FG:    r_shFg   <= cfg_wdata;
          default: begin
            for (int i = 0; i < N_CHARS; i++) begin
              if (w_codeSel && (int'(w_codeIdx) == i)) begin
                r_shCode[i] <= cfg_wdata[CODE_W-1:0];
              end
            end
          end
        endcase
      end
      if (w_accept) begin
        r_dirty <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !r_ctrl.mode[0]) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (frame_start) begin
      if (int'(r_blinkCnt) == BLINK_FRAMES - 1) begin
        r_blinkCnt   <= '0;
        r_blinkPhase <= !r_blinkPhase;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  assign o_orgX    = r_orgX;
  assign o_orgY    = r_orgY;
  assign o_fg      = r_fg;
  assign o_code    = r_code;
  assign o_enable  = r_ctrl.enable;
  assign o_visible = !r_blinkPhase;

endmodule

// File: rtl/hz_text_layer.sv
// Text overlay layer: a row of N_CHARS 16x16 glyphs fetched from an external
// glyph ROM, with a fixed two-cycle scan-to-pixel latency.
module hz_text_layer
  import hz_layer_pkg::*;
#(
  parameter int N_CHARS      = 3,
  parameter int PITCH        = 32,
  parameter int N_GLYPHS     = 4,
  parameter int H_ACTIVE     = 640,
  parameter int ORG_X_RST    = 512,
  parameter int ORG_Y_RST    = 96,
  parameter int BLINK_FRAMES = 30,
  parameter int SCROLL_STEP  = 1,
  parameter int TRANSPARENT  = 0,
  localparam int ROM_AW      = $clog2(N_GLYPHS * BYTES_PER_GLYPH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x_pos,
  input  logic [8:0]        y_pos,
  input  logic              frame_start,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [23:0]       cfg_wdata,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_dout,
  output logic              RqFlag,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b
);

  localparam int CODE_W   = (N_GLYPHS > 1) ? $clog2(N_GLYPHS) : 1;
  localparam int SLOT_SH  = $clog2(PITCH);
  localparam int SLOT_W   = 10 - SLOT_SH;
  localparam bit IS_TRANS = (TRANSPARENT != 0);

  logic [9:0]                     w_orgX;
  logic [8:0]                     w_orgY;
  logic [23:0]                    w_fg;
  logic [N_CHARS-1:0][CODE_W-1:0] w_codes;
  logic                           w_enable;
  logic                           w_visible;

  logic [9:0]         w_dx, w_dy;
  logic [SLOT_W-1:0]  w_slot;
  logic [SLOT_SH-1:0] w_col;
  logic [CODE_W-1:0]  w_code;
  logic [CODE_W+4:0]  w_romAddr;
  logic               w_hit;
  logic               w_pixel;

  logic       r_hit1;
  logic [2:0] r_colLo1;

  hz_layer_timing #(
    .N_CHARS      (N_CHARS),
    .N_GLYPHS     (N_GLYPHS),
    .H_ACTIVE     (H_ACTIVE),
    .ORG_X_RST    (ORG_X_RST),
    .ORG_Y_RST    (ORG_Y_RST),
    .BLINK_FRAMES (BLINK_FRAMES),
    .SCROLL_STEP  (SCROLL_STEP),
    .CODE_W       (CODE_W)
  ) uTiming (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .o_orgX      (w_orgX),
    .o_orgY      (w_orgY),
    .o_fg        (w_fg),
    .o_code      (w_codes),
    .o_enable    (w_enable),
    .o_visible   (w_visible)
  );

  assign w_dx   = x_pos - w_orgX;
  assign w_dy   = {1'b0, y_pos} - {1'b0, w_orgY};
  assign w_slot = w_dx[9:SLOT_SH];
  assign w_col  = w_dx[SLOT_SH-1:0];
  assign w_hit  = w_enable && w_visible && (w_dy < 10'(GLYPH_H))
                  && (int'(w_col) < GLYPH_W) && (int'(w_slot) < N_CHARS);

  always_comb begin
    w_code = '0;
    for (int i = 0; i < N_CHARS; i++) begin
      if (int'(w_slot) == i) begin
        w_code = w_codes[i];
      end
    end
  end

  // Two bytes per glyph row: col[3] picks the left or right half.
  assign w_romAddr = {w_code, w_dy[3:0], w_col[3]};
  assign w_pixel   = rom_dout[3'd7 - r_colLo1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      r_hit1   <= 1'b0;
      r_colLo1 <= '0;
      RqFlag   <= 1'b0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
    end else begin
      rom_addr <= w_romAddr[ROM_AW-1:0];
      r_hit1   <= w_hit;
      r_colLo1 <= w_col[2:0];
      RqFlag   <= r_hit1 && (w_pixel || !IS_TRANS);
      if (r_hit1 && w_pixel) begin
        {r, g, b} <= w_fg;
      end else begin
        {r, g, b} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hz_text_layer.sv
// Bench for hz_text_layer: two instances (transparent and opaque cells)
// checked every cycle against a frame-level model, plus pinned literals.
module tb_hz_text_layer;

  localparam int ROM_AW = 7;
  localparam int NC     = 3;
  localparam int BLINK  = 2;
  localparam int STEP   = 1;
  localparam int HACT   = 640;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [9:0]        xPos;
  logic [8:0]        yPos;
  logic              frameStart;
  logic              cfgWe;
  logic [4:0]        cfgAddr;
  logic [23:0]       cfgWdata;
  logic [ROM_AW-1:0] romAddrA, romAddrB;
  logic [7:0]        romDoutA, romDoutB;
  logic              rqA, rqB;
  logic [7:0]        rA, gA, bA, rB, gB, bB;
  logic [7:0]        rom [128];

  assign romDoutA = rom[romAddrA];
  assign romDoutB = rom[romAddrB];

  int compared = 0;
  int mismatched = 0;

  hz_text_layer #(.BLINK_FRAMES(BLINK), .TRANSPARENT(1)) dutA (
    .clk(clk), .rst(rst), .x_pos(xPos), .y_pos(yPos), .frame_start(frameStart),
    .cfg_we(cfgWe), .cfg_addr(cfgAddr), .cfg_wdata(cfgWdata),
    .rom_addr(romAddrA), .rom_dout(romDoutA), .RqFlag(rqA), .r(rA), .g(gA), .b(bA)
  );

  hz_text_layer #(.BLINK_FRAMES(BLINK), .TRANSPARENT(0)) dutB (
    .clk(clk), .rst(rst), .x_pos(xPos), .y_pos(yPos), .frame_start(frameStart),
    .cfg_we(cfgWe), .cfg_addr(cfgAddr), .cfg_wdata(cfgWdata),
    .rom_addr(romAddrB), .rom_dout(romDoutB), .RqFlag(rqB), .r(rB), .g(gB), .b(bB)
  );

  typedef struct {
    bit        en;
    bit [1:0]  mode;
    int        orgX;
    int        orgY;
    bit [23:0] fg;
    int        code [NC];
  } cfg_t;

  cfg_t shadowCfg, activeCfg;
  bit   dirty;
  int   blinkCnt;
  bit   blinkPhase;
  bit   modelReady = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic cfg_t defaultCfg();
    cfg_t c;
    c.en = 1'b0; c.mode = 2'b00; c.orgX = 512; c.orgY = 96; c.fg = 24'hFFFFFF;
    for (int i = 0; i < NC; i++) c.code[i] = i % 4;
    return c;
  endfunction

  // Config state change caused by one clock edge with the current inputs.
  task automatic modelEdge();
    bit [1:0] modeBefore;
    if (rst) begin
      shadowCfg = defaultCfg(); activeCfg = shadowCfg;
      dirty = 1'b0; blinkCnt = 0; blinkPhase = 1'b0; modelReady = 1'b1;
      return;
    end
    modeBefore = activeCfg.mode;
    if (frameStart) begin
      if (dirty) begin
        activeCfg = shadowCfg; dirty = 1'b0;
      end else if (activeCfg.mode[1]) begin
        activeCfg.orgX = (activeCfg.orgX >= STEP) ? activeCfg.orgX - STEP : activeCfg.orgX + HACT - STEP;
        shadowCfg.orgX = activeCfg.orgX;
      end
    end
    if (!modeBefore[0]) begin
      blinkCnt = 0; blinkPhase = 1'b0;
    end else if (frameStart) begin
      if (blinkCnt == BLINK - 1) begin blinkCnt = 0; blinkPhase = !blinkPhase; end
      else blinkCnt++;
    end
    if (cfgWe) begin
      case (int'(cfgAddr))
        0: begin shadowCfg.en = cfgWdata[2]; shadowCfg.mode = cfgWdata[1:0]; dirty = 1'b1; end
        1: begin shadowCfg.orgX = int'(cfgWdata[9:0]); dirty = 1'b1; end
        2: begin shadowCfg.orgY = int'(cfgWdata[8:0]); dirty = 1'b1; end
        3: begin shadowCfg.fg = cfgWdata; dirty = 1'b1; end
        8, 9, 10: begin shadowCfg.code[int'(cfgAddr) - 8] = int'(cfgWdata) % 4; dirty = 1'b1; end
        default: ;
      endcase
    end
  endtask

  function automatic void expectAt(input int x, input int y, output bit hit, output int addr, output bit pix);
    int dx, dy, slot, col, byteVal;
    dx   = (x - activeCfg.orgX + 2048) % 1024;
    dy   = (y - activeCfg.orgY + 2048) % 1024;
    slot = dx / 32;
    col  = dx % 32;
    hit  = activeCfg.en && !blinkPhase && dy < 16 && col < 16 && slot < NC;
    addr = 0;
    pix  = 1'b0;
    if (hit) begin
      addr    = activeCfg.code[slot] * 32 + dy * 2 + col / 8;
      byteVal = int'(rom[addr]);
      pix     = ((byteVal >> (7 - col % 8)) & 1) == 1;
    end
  endfunction

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin : compare
    bit        s1Valid = 1'b0, s1Hit = 1'b0, s1Reset = 1'b0, s1Pix = 1'b0;
    int        s1Addr = 0;
    bit        oValid = 1'b0, oRqA = 1'b0, oRqB = 1'b0;
    bit [23:0] oRgb = '0;
    forever begin
      @(negedge clk);
      if (oValid) begin
        checkOutput("cyc_rq_a", rqA, oRqA);
        checkOutput("cyc_rq_b", rqB, oRqB);
        checkOutput("cyc_rgb_a", {rA, gA, bA}, oRgb);
        checkOutput("cyc_rgb_b", {rB, gB, bB}, oRgb);
      end
      if (s1Valid && (s1Hit || s1Reset)) begin
        checkOutput("cyc_romaddr_a", romAddrA, s1Addr);
        checkOutput("cyc_romaddr_b", romAddrB, s1Addr);
      end
      if (rst) begin
        oValid = 1'b1; oRqA = 1'b0; oRqB = 1'b0; oRgb = '0;
        s1Valid = 1'b1; s1Hit = 1'b0; s1Reset = 1'b1; s1Addr = 0;
      end else begin
        oValid = s1Valid;
        oRqA   = s1Hit && s1Pix;
        oRqB   = s1Hit;
        oRgb   = (s1Hit && s1Pix) ? activeCfg.fg : 24'h0;
        s1Reset = 1'b0;
        s1Valid = modelReady;
        if (modelReady) expectAt(int'(xPos), int'(yPos), s1Hit, s1Addr, s1Pix);
      end
      modelEdge();
    end
  end

  task automatic applyStimulus(input int x, input int y, input bit fs, input bit we, input int addr, input int data);
    @(posedge clk); #1;
    xPos = 10'(x); yPos = 9'(y); frameStart = fs; cfgWe = we;
    cfgAddr = 5'(addr); cfgWdata = 24'(data);
  endtask

  task automatic idle();           applyStimulus(0, 0, 1'b0, 1'b0, 0, 0); endtask
  task automatic frame();          applyStimulus(0, 0, 1'b1, 1'b0, 0, 0); idle(); endtask
  task automatic cfgWrite(input int a, input int d);        applyStimulus(0, 0, 1'b0, 1'b1, a, d); idle(); endtask
  task automatic cfgWriteAtFrame(input int a, input int d); applyStimulus(0, 0, 1'b1, 1'b1, a, d); idle(); endtask

  task automatic scanLine(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) applyStimulus(x, y, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic scanPoint(input int x, input int y);
    applyStimulus(x, y, 1'b0, 1'b0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
  endtask

  initial begin : main
    rst = 1'b1; xPos = '0; yPos = '0; frameStart = 1'b0; cfgWe = 1'b0; cfgAddr = '0; cfgWdata = '0;
    for (int a = 0; a < 128; a++) rom[a] = 8'((a * 37 + 11) ^ (a >> 2));
    rom[0] = 8'b1000_0001;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rq_a", rqA, 0);
    checkOutput("reset_rgb_b", {rB, gB, bB}, 0);
    checkOutput("reset_romaddr_a", romAddrA, 0);
    rst = 1'b0;

    $display("[TB] enable at reset origin");
    cfgWrite(0, 3'b100);
    frame();
    scanLine(100, 505, 590);
    scanPoint(520, 100); checkOutput("addr_x520_y100", romAddrA, 9);
    checkOutput("slot0_rq", rqB, 1);
    scanPoint(511, 100); checkOutput("left_of_slot0", rqB, 0);
    scanPoint(528, 100); checkOutput("col16_gap", rqB, 0);
    scanPoint(544, 100); checkOutput("slot1_rq", rqB, 1);
    scanPoint(576, 100); checkOutput("slot2_rq", rqB, 1);
    scanPoint(608, 100); checkOutput("slot3_none", rqB, 0);

    $display("[TB] transparent row with green fg");
    cfgWrite(3, 24'h00FF00);
    frame();
    scanLine(96, 510, 530);
    scanPoint(512, 96); checkOutput("col0_rq_a", rqA, 1); checkOutput("col0_rgb_a", {rA, gA, bA}, 24'h00FF00);
    scanPoint(513, 96); checkOutput("col1_rq_a", rqA, 0); checkOutput("col1_g_a", gA, 0);
    checkOutput("col1_rq_b", rqB, 1);
    scanPoint(519, 96); checkOutput("col7_rq_a", rqA, 1); checkOutput("col7_g_a", gA, 8'hFF);

    $display("[TB] origin write commit timing");
    cfgWrite(1, 100);
    scanPoint(512, 100); checkOutput("org_pending_old", rqB, 1);
    scanPoint(100, 100); checkOutput("org_pending_new", rqB, 0);
    frame();
    scanPoint(100, 100); checkOutput("org_committed", rqB, 1);
    scanPoint(512, 100); checkOutput("org_old_gone", rqB, 0);
    cfgWriteAtFrame(1, 200);
    scanPoint(200, 100); checkOutput("coincident_not_yet", rqB, 0);
    scanPoint(100, 100); checkOutput("coincident_keep", rqB, 1);
    frame();
    scanPoint(200, 100); checkOutput("coincident_later", rqB, 1);

    $display("[TB] marquee wrap");
    cfgWrite(0, 3'b110);
    cfgWrite(1, 0);
    frame();
    scanPoint(0, 100); checkOutput("marq_org0", rqB, 1);
    frame();
    scanPoint(639, 100); checkOutput("marq_org639", rqB, 1);
    scanPoint(0, 100); checkOutput("marq_x0_gone", rqB, 0);
    repeat (3) frame();
    scanPoint(636, 100); checkOutput("marq_org636", rqB, 1);
    scanPoint(635, 100); checkOutput("marq_x635", rqB, 0);
    scanLine(100, 630, 645);

    $display("[TB] blink");
    cfgWrite(0, 3'b101);
    cfgWrite(1, 512);
    frame();
    for (int f = 0; f < 6; f++) begin
      scanPoint(512, 100);
      checkOutput($sformatf("blink_f%0d", f), rqB, (f == 2 || f == 3) ? 0 : 1);
      frame();
    end

    $display("[TB] codes then reset mid-scan");
    cfgWrite(0, 3'b100);
    cfgWrite(8, 3);
    cfgWrite(10, 1);
    frame();
    scanPoint(512, 100); checkOutput("code0_is3", romAddrA, 104);
    scanPoint(576, 100); checkOutput("code2_is1", romAddrA, 40);
    scanPoint(516, 100); checkOutput("prereset_hit", rqB, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_rq_b", rqB, 0);
    checkOutput("midreset_rgb_b", {rB, gB, bB}, 0);
    checkOutput("midreset_romaddr", romAddrA, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cfgWrite(0, 3'b100);
    frame();
    scanPoint(512, 100); checkOutput("dflt_code0", romAddrA, 8); checkOutput("dflt_slot0", rqB, 1);
    scanPoint(544, 100); checkOutput("dflt_code1", romAddrA, 40);
    scanPoint(576, 100); checkOutput("dflt_code2", romAddrA, 72);
    scanPoint(512, 96); checkOutput("dflt_orgy_rq_a", rqA, 1); checkOutput("dflt_fg_r", rA, 8'hFF);
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
